// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer with operand forwarding; optional ROB_EXCEPTION_EN
`ifndef ARCH_REG_INDEX_SIZE
`define ARCH_REG_INDEX_SIZE 5
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 3
`endif

module reorder_buffer #(
    parameter int ARCH_REG_INDEX_SIZE = `ARCH_REG_INDEX_SIZE,
    parameter int ROB_ENTRY_WIDTH     = `ROB_ENTRY_WIDTH,
    parameter int DATA_WIDTH          = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           alloc_valid,
    input  logic [ARCH_REG_INDEX_SIZE-1:0] alloc_rd,
    output logic                           alloc_ready,
    output logic [ROB_ENTRY_WIDTH-1:0]     alloc_rob_id,
    input  logic                           wb_valid,
    input  logic [ROB_ENTRY_WIDTH-1:0]     wb_rob_id,
    input  logic [DATA_WIDTH-1:0]          wb_value,
    input  logic                           wb_exception,
    input  logic [ROB_ENTRY_WIDTH-1:0]     rs1_rob_entry,
    input  logic [ROB_ENTRY_WIDTH-1:0]     rs2_rob_entry,
    output logic [DATA_WIDTH-1:0]          rs1_value,
    output logic                           rs1_value_valid,
    output logic [DATA_WIDTH-1:0]          rs2_value,
    output logic                           rs2_value_valid,
    output logic                           commit,
    output logic [ARCH_REG_INDEX_SIZE-1:0] commit_rd,
    output logic [ROB_ENTRY_WIDTH-1:0]     commit_rob_id,
    output logic [DATA_WIDTH-1:0]          commit_value,
    input  logic                           flush,
    output logic                           exception,
    output logic [ROB_ENTRY_WIDTH-1:0]     exception_rob_id
);

    localparam int ENTRIES = 1 << ROB_ENTRY_WIDTH;
    localparam logic [ROB_ENTRY_WIDTH:0] FULL_COUNT = {1'b1, {ROB_ENTRY_WIDTH{1'b0}}};

    logic [ENTRIES-1:0]             busy_q, busy_d;
    logic [ENTRIES-1:0]             done_q, done_d;
    logic [ENTRIES-1:0]             exc_q, exc_d;
    logic [ROB_ENTRY_WIDTH-1:0]     head_q, head_d;
    logic [ROB_ENTRY_WIDTH-1:0]     tail_q, tail_d;
    logic [ROB_ENTRY_WIDTH:0]       count_q, count_d;
    logic [ARCH_REG_INDEX_SIZE-1:0] rd_q [ENTRIES];
    logic [DATA_WIDTH-1:0]          value_q [ENTRIES];

    logic do_alloc;
    logic wb_hit;
    logic wb_exc_eff;
    logic head_ready;
    logic flush_all;
    logic rs1_fwd;
    logic rs2_fwd;

    assign alloc_ready  = (count_q != FULL_COUNT);
    assign alloc_rob_id = tail_q;
    assign do_alloc     = alloc_valid && alloc_ready;
    assign wb_hit       = wb_valid && busy_q[wb_rob_id];
    assign head_ready   = busy_q[head_q] && done_q[head_q];

`ifdef ROB_EXCEPTION_EN
    // A faulting head is reported instead of retired and squashes the buffer on the next edge.
    assign wb_exc_eff       = wb_exception;
    assign exception        = head_ready && exc_q[head_q];
    assign exception_rob_id = exception ? head_q : '0;
`else
    logic unused_wb_exception;
    assign unused_wb_exception = wb_exception;
    assign wb_exc_eff          = 1'b0;
    assign exception           = 1'b0;
    assign exception_rob_id    = '0;
`endif

    assign flush_all     = flush || exception;
    assign commit        = head_ready && !exc_q[head_q] && !flush;
    assign commit_rob_id = head_q;
    assign commit_rd     = rd_q[head_q];
    assign commit_value  = value_q[head_q];

    // Operand lookup: a same-cycle writeback to a live entry bypasses the stored value.
    assign rs1_fwd         = wb_valid && (wb_rob_id == rs1_rob_entry);
    assign rs1_value_valid = busy_q[rs1_rob_entry] && (done_q[rs1_rob_entry] || rs1_fwd);
    assign rs1_value       = !busy_q[rs1_rob_entry] ? '0 :
                             (rs1_fwd ? wb_value : value_q[rs1_rob_entry]);
    assign rs2_fwd         = wb_valid && (wb_rob_id == rs2_rob_entry);
    assign rs2_value_valid = busy_q[rs2_rob_entry] && (done_q[rs2_rob_entry] || rs2_fwd);
    assign rs2_value       = !busy_q[rs2_rob_entry] ? '0 :
                             (rs2_fwd ? wb_value : value_q[rs2_rob_entry]);

    // Next-state for entry flags and pointers; a squash wins over everything else.
    always_comb begin
        busy_d  = busy_q;
        done_d  = done_q;
        exc_d   = exc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_all) begin
            busy_d  = '0;
            done_d  = '0;
            exc_d   = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wb_hit) begin
                done_d[wb_rob_id] = 1'b1;
                exc_d[wb_rob_id]  = wb_exc_eff;
            end
            if (commit) begin
                busy_d[head_q] = 1'b0;
                head_d         = head_q + 1'b1;
            end
            if (do_alloc) begin
                busy_d[tail_q] = 1'b1;
                done_d[tail_q] = 1'b0;
                exc_d[tail_q]  = 1'b0;
                tail_d         = tail_q + 1'b1;
            end
            case ({do_alloc, commit})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q  <= '0;
            done_q  <= '0;
            exc_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            exc_q   <= exc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage; contents are only observed through busy-qualified outputs.
    always_ff @(posedge clk) begin
        if (do_alloc && !flush_all) begin
            rd_q[tail_q] <= alloc_rd;
        end
        if (wb_hit && !flush_all) begin
            value_q[wb_rob_id] <= wb_value;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - self-checking bench for reorder_buffer
module tb_reorder_buffer;

    localparam int AW = 5;
    localparam int RW = 3;
    localparam int DW = 32;
    localparam int N  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          alloc_valid = 1'b0;
    logic [AW-1:0] alloc_rd = '0;
    logic          alloc_ready;
    logic [RW-1:0] alloc_rob_id;
    logic          wb_valid = 1'b0;
    logic [RW-1:0] wb_rob_id = '0;
    logic [DW-1:0] wb_value = '0;
    logic          wb_exception = 1'b0;
    logic [RW-1:0] rs1_rob_entry = '0;
    logic [RW-1:0] rs2_rob_entry = '0;
    logic [DW-1:0] rs1_value, rs2_value;
    logic          rs1_value_valid, rs2_value_valid;
    logic          commit;
    logic [AW-1:0] commit_rd;
    logic [RW-1:0] commit_rob_id;
    logic [DW-1:0] commit_value;
    logic          flush = 1'b0;
    logic          exception;
    logic [RW-1:0] exception_rob_id;

    reorder_buffer #(.ARCH_REG_INDEX_SIZE(AW), .ROB_ENTRY_WIDTH(RW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_rob_id(alloc_rob_id),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
        .wb_exception(wb_exception),
        .rs1_rob_entry(rs1_rob_entry), .rs2_rob_entry(rs2_rob_entry),
        .rs1_value(rs1_value), .rs1_value_valid(rs1_value_valid),
        .rs2_value(rs2_value), .rs2_value_valid(rs2_value_valid),
        .commit(commit), .commit_rd(commit_rd), .commit_rob_id(commit_rob_id),
        .commit_value(commit_value), .flush(flush),
        .exception(exception), .exception_rob_id(exception_rob_id)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: program-order queue of in-flight ids plus per-id result tables.
    int            q[$];
    int            mtail = 0;
    bit            mbusy [N];
    bit            mdone [N];
    bit            mexc  [N];
    bit [AW-1:0]   mrd   [N];
    bit [DW-1:0]   mval  [N];

    task automatic m_clear();
        q.delete();
        mtail = 0;
        for (int i = 0; i < N; i++) mbusy[i] = 1'b0;
    endtask

    task automatic check_rs(input string name, input int id, input logic v, input logic [DW-1:0] val);
        bit hit;
        hit = wb_valid && (int'(wb_rob_id) == id);
        check({name, "_valid"}, v, mbusy[id] && (mdone[id] || hit));
        if (!mbusy[id]) check({name, "_zero"}, val, 0);
        else if (mdone[id] || hit) check({name, "_value"}, val, hit ? wb_value : mval[id]);
    endtask

    // Compare against the model, then advance the model to the state after the coming edge.
    always @(negedge clk) begin : cmp
        bit has, hd, hx, ec, full;
        int h;
        if (!reset) m_clear();
        has = q.size() > 0;
        h   = has ? q[0] : 0;
        hd  = has && mdone[h];
        hx  = hd && mexc[h];
        ec  = hd && !hx && !flush;
        full = q.size() == N;
        check("m_alloc_ready", alloc_ready, !full);
        check("m_alloc_rob_id", alloc_rob_id, mtail);
        check("m_commit", commit, ec);
        if (ec) begin
            check("m_commit_rob_id", commit_rob_id, h);
            check("m_commit_rd", commit_rd, mrd[h]);
            check("m_commit_value", commit_value, mval[h]);
        end
        check("m_exception", exception, hx);
        check("m_exception_rob_id", exception_rob_id, hx ? h : 0);
        check_rs("m_rs1", int'(rs1_rob_entry), rs1_value_valid, rs1_value);
        check_rs("m_rs2", int'(rs2_rob_entry), rs2_value_valid, rs2_value);
        if (reset) begin
            if (flush || hx) begin
                m_clear();
            end else begin
                if (wb_valid && mbusy[wb_rob_id]) begin
                    mdone[wb_rob_id] = 1'b1;
                    mval[wb_rob_id]  = wb_value;
`ifdef ROB_EXCEPTION_EN
                    mexc[wb_rob_id]  = wb_exception;
`else
                    mexc[wb_rob_id]  = 1'b0;
`endif
                end
                if (ec) begin
                    mbusy[h] = 1'b0;
                    void'(q.pop_front());
                end
                if (alloc_valid && !full) begin
                    mbusy[mtail] = 1'b1;
                    mdone[mtail] = 1'b0;
                    mexc[mtail]  = 1'b0;
                    mrd[mtail]   = alloc_rd;
                    q.push_back(mtail);
                    mtail = (mtail + 1) % N;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic wb(input int id, input logic [DW-1:0] v);
        wb_valid  = 1'b1;
        wb_rob_id = RW'(id);
        wb_value  = v;
    endtask

    initial begin
        #1 reset = 1'b0;
        neg();
        check("rst_ready", alloc_ready, 1);
        check("rst_id", alloc_rob_id, 0);
        check("rst_commit", commit, 0);
        check("rst_exception", exception, 0);
        check("rst_rs1_valid", rs1_value_valid, 0);
        cyc();
        reset = 1'b1;

        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1;
            alloc_rd    = AW'(5 + i);
            neg();
            check("alloc_id", alloc_rob_id, i);
            cyc();
        end
        alloc_valid = 1'b0;
        neg();
        check("alloc3_commit", commit, 0);

        wb(2, 32'hAA);
        cyc();
        wb(0, 32'h11);
        neg();
        check("wb_latency", commit, 0);
        cyc();
        wb_valid = 1'b0;
        neg();
        check("c0_commit", commit, 1);
        check("c0_id", commit_rob_id, 0);
        check("c0_value", commit_value, 32'h11);
        check("c0_rd", commit_rd, 5);
        cyc();
        neg();
        check("hold_for_id1", commit, 0);
        wb(1, 32'h22);
        cyc();
        wb_valid = 1'b0;
        neg();
        check("c1_id", commit_rob_id, 1);
        cyc();
        neg();
        check("c2_id", commit_rob_id, 2);
        check("c2_value", commit_value, 32'hAA);
        cyc();

        flush = 1'b1;
        cyc();
        flush = 1'b0;
        neg();
        check("flush_empty_id", alloc_rob_id, 0);

        for (int i = 0; i < N; i++) begin
            alloc_valid = 1'b1;
            alloc_rd    = AW'(i + 1);
            cyc();
        end
        alloc_rd = AW'(9);
        wb(0, 32'h100);
        neg();
        check("full_ready", alloc_ready, 0);
        cyc();
        wb(1, 32'h101);
        neg();
        check("full_commit", commit, 1);
        check("full_ready_commit", alloc_ready, 0);
        check("ninth_ignored", alloc_rob_id, 0);
        cyc();
        wb_valid = 1'b0;
        alloc_rd = AW'(10);
        neg();
        check("c7_commit_id", commit_rob_id, 1);
        check("c7_ready", alloc_ready, 1);
        check("wrap_id", alloc_rob_id, 0);
        cyc();
        alloc_valid = 1'b0;
        neg();
        check("after_wrap_id", alloc_rob_id, 1);
        check("after_wrap_commit", commit, 0);

        wb(4, 32'h55);
        rs1_rob_entry = RW'(4);
        rs2_rob_entry = RW'(5);
        neg();
        check("fwd_valid", rs1_value_valid, 1);
        check("fwd_value", rs1_value, 32'h55);
        check("rs2_pending", rs2_value_valid, 0);
        cyc();
        wb_valid = 1'b0;
        neg();
        check("stored_value", rs1_value, 32'h55);

        wb(2, 32'h202);
        cyc();
        wb_valid = 1'b0;
        flush    = 1'b1;
        neg();
        check("flush_blocks_commit", commit, 0);
        cyc();
        flush = 1'b0;
        neg();
        check("post_flush_id", alloc_rob_id, 0);
        check("post_flush_ready", alloc_ready, 1);
        check("post_flush_rs1", rs1_value_valid, 0);

        alloc_valid = 1'b1;
        alloc_rd    = AW'(3);
        cyc();
        alloc_valid = 1'b0;
        wb(0, 32'h300);
        cyc();
        wb_valid    = 1'b0;
        alloc_valid = 1'b1;
        alloc_rd    = AW'(4);
        neg();
        check("one_commit", commit, 1);
        check("one_commit_rd", commit_rd, 3);
        cyc();
        alloc_valid = 1'b0;
        neg();
        check("one_after_id", alloc_rob_id, 2);

        wb(1, 32'h77);
        wb_exception = 1'b1;
        cyc();
        wb_valid     = 1'b0;
        wb_exception = 1'b0;
        neg();
`ifdef ROB_EXCEPTION_EN
        check("exc_flag", exception, 1);
        check("exc_id", exception_rob_id, 1);
        check("exc_no_commit", commit, 0);
        cyc();
        neg();
        check("exc_empty_id", alloc_rob_id, 0);
`else
        check("exc_ignored_commit", commit, 1);
        check("exc_ignored_value", commit_value, 32'h77);
        check("exc_tied", exception, 0);
        cyc();
        neg();
        check("exc_ignored_id", alloc_rob_id, 2);
`endif

        wb(5, 32'h99);
        cyc();
        wb_valid      = 1'b0;
        rs1_rob_entry = RW'(5);
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1'b1;
            alloc_rd    = AW'(20 + i);
            cyc();
        end
        alloc_valid = 1'b0;
        cyc();

        reset = 1'b0;
        neg();
        check("midrst_id", alloc_rob_id, 0);
        check("midrst_commit", commit, 0);
        check("midrst_rs1", rs1_value_valid, 0);
        cyc();
        reset = 1'b1;
        neg();
        check("midrst_ready", alloc_ready, 1);
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
